// File: rtl/clock_pkg.sv
// -----------------------------------------------------------------------------
// clock_pkg
// Shared types and constants for the calendar/time display path.
//   bcd_state_t    : sequencer states of the binary-to-BCD converter
//   BCD_DIGIT_W    : bits per packed BCD digit
//   BCD_NINE       : largest BCD digit, used to saturate on overflow
//   max_bcd_value(): largest value representable in a given number of digits
// -----------------------------------------------------------------------------
package clock_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } bcd_state_t;

    localparam int         BCD_DIGIT_W = 4;
    localparam logic [3:0] BCD_NINE    = 4'h9;

    // 10^digits - 1, evaluated at elaboration time for parameterised limits
    function automatic int unsigned max_bcd_value(input int digits);
        int unsigned v;
        v = 32'd1;
        for (int i = 0; i < digits; i++) begin
            v = v * 32'd10;
        end
        return v - 32'd1;
    endfunction

endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// -----------------------------------------------------------------------------
// bin_to_bcd_seq_if
// Input and output valid/ready channels of the binary-to-BCD converter.
//   in_valid/in_ready/in_bin          : binary value offered by the producer
//   out_valid/out_ready/out_bcd/out_ovf: packed BCD result and overflow flag
// Modports: master = producer/consumer side, slave = converter side.
// -----------------------------------------------------------------------------
interface bin_to_bcd_seq_if
    import clock_pkg::*;
#(
    parameter int IN_W   = 14,
    parameter int DIGITS = 4
);
    logic                          in_valid;
    logic                          in_ready;
    logic [IN_W-1:0]               in_bin;
    logic                          out_valid;
    logic                          out_ready;
    logic [BCD_DIGIT_W*DIGITS-1:0] out_bcd;
    logic                          out_ovf;

    modport master (
        output in_valid, in_bin, out_ready,
        input  in_ready, out_valid, out_bcd, out_ovf
    );

    modport slave (
        input  in_valid, in_bin, out_ready,
        output in_ready, out_valid, out_bcd, out_ovf
    );
endinterface

// File: rtl/bin_to_bcd_seq_digit_adj.sv
// -----------------------------------------------------------------------------
// bcd_digit_adj
// Combinational "add 3 if >= 5" correction for one BCD digit, applied before
// each left shift so that a digit reaching 10 carries into the next decade.
//   digit_in  : current accumulator digit
//   digit_out : corrected digit
// -----------------------------------------------------------------------------
module bcd_digit_adj
    import clock_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit_in,
    output logic [BCD_DIGIT_W-1:0] digit_out
);

    // Digit correction ahead of the doubling shift
    always_comb begin
        digit_out = digit_in;
        if (digit_in >= 4'd5) begin
            digit_out = digit_in + 4'd3;
        end else begin
            digit_out = digit_in;
        end
    end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// -----------------------------------------------------------------------------
// bin_to_bcd_seq
// Sequential shift-and-add-3 binary-to-BCD converter, one input bit per cycle.
// Results above 10^DIGITS-1 saturate to all nines and raise out_ovf.
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : slave side of bin_to_bcd_seq_if (in_* accept channel,
//            out_* result channel, both valid/ready)
// Latency is IN_W cycles from acceptance to out_valid.
// -----------------------------------------------------------------------------
module bin_to_bcd_seq
    import clock_pkg::*;
#(
    parameter int IN_W   = 14,
    parameter int DIGITS = 4
)(
    input  logic                   clk,
    input  logic                   rst_n,
    bin_to_bcd_seq_if.slave        bus
);

    localparam int                 ACC_W     = BCD_DIGIT_W * DIGITS;
    localparam int                 CNT_W     = $clog2(IN_W + 1);
    localparam int unsigned        MAX_VAL   = max_bcd_value(DIGITS);
    localparam logic [ACC_W-1:0]   ALL_NINES = {DIGITS{BCD_NINE}};

    bcd_state_t         state_r;
    logic [IN_W-1:0]    shift_r;
    logic [ACC_W-1:0]   acc_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               ovf_r;
    logic [ACC_W-1:0]   out_bcd_r;
    logic               out_ovf_r;

    logic [ACC_W-1:0]   adj_s;
    logic [ACC_W-1:0]   acc_next_s;
    logic               ovf_in_s;
    logic               unused_top_s;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit_in  (acc_r[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .digit_out (adj_s[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    // Corrected digits doubled, next binary MSB entering at bit 0; the bit
    // leaving the top digit only matters on overflow, which saturates anyway
    assign acc_next_s   = {adj_s[ACC_W-2:0], shift_r[IN_W-1]};
    assign unused_top_s = adj_s[ACC_W-1];

    // Overflow is decided once on acceptance, from the full-width input
    assign ovf_in_s = (32'(bus.in_bin) > MAX_VAL);

    assign bus.in_ready  = (state_r == IDLE);
    assign bus.out_valid = (state_r == DONE);
    assign bus.out_bcd   = out_bcd_r;
    assign bus.out_ovf   = out_ovf_r;

    // Conversion sequencer: load, IN_W correct-and-shift steps, hold result until taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            shift_r   <= '0;
            acc_r     <= '0;
            cnt_r     <= '0;
            ovf_r     <= 1'b0;
            out_bcd_r <= '0;
            out_ovf_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.in_valid) begin
                        shift_r <= bus.in_bin;
                        acc_r   <= '0;
                        ovf_r   <= ovf_in_s;
                        cnt_r   <= CNT_W'(IN_W);
                        state_r <= SHIFT;
                    end
                end
                SHIFT: begin
                    acc_r   <= acc_next_s;
                    shift_r <= shift_r << 1'b1;
                    cnt_r   <= cnt_r - CNT_W'(1);
                    if (cnt_r == CNT_W'(1)) begin
                        out_bcd_r <= ovf_r ? ALL_NINES : acc_next_s;
                        out_ovf_r <= ovf_r;
                        state_r   <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule
